div_rem_sgn_seq: RTL and testbench
==================================

DIV_REM_SGN_SEQ -- requirements
Module: div_rem_sgn_seq

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the word width of dividend, divisor, quotient and remainder (>= 2).
REQ-002 The block SHALL have parameter speed, default lau_pkg::FAST, selecting the implementation of internal adders; it SHALL NOT affect results or latency.
REQ-003 clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 in_valid_i  input  1  an operand pair is offered.
REQ-006 in_ready_o  output  1  the block accepts an operand pair this cycle.
REQ-007 N_i  input  width  signed dividend.
REQ-008 D_i  input  width  signed divisor.
REQ-009 out_valid_o  output  1  Q_o/R_o hold a valid result.
REQ-010 out_ready_i  input  1  the consumer takes the result this cycle.
REQ-011 Q_o  output  width  signed quotient.
REQ-012 R_o  output  width  signed remainder.

Function
REQ-013 Results SHALL satisfy N = Q*D + R (two's complement, width bits), with Q truncated toward zero, R carrying the sign of N or zero, and |R| < |D|.
REQ-014 States SHALL be IDLE, CALC and DONE; reset state IDLE.
REQ-015 in_ready_o SHALL be 1 exactly in IDLE; out_valid_o SHALL be 1 exactly in DONE.
REQ-016 Accept: in IDLE with in_valid_i=1, the block SHALL register N_i, D_i, sign(N), sign(N) xor sign(D), |N| and |D| at that edge.
REQ-017 Normal path: IDLE->CALC on accept; CALC SHALL run exactly width cycles with radix-2 restoring or non-restoring iteration on |N| and |D|, producing one quotient bit per cycle under a counter 0..width-1.
REQ-018 CALC->DONE at the edge where the counter equals width-1; the sign-corrected Q and R SHALL be registered at that edge.
REQ-019 Normal-path latency: out_valid_o SHALL first be 1 in the cycle width+1 edges after the accept edge.
REQ-020 Divide by zero (D_i=0): IDLE->DONE directly, with Q_o = all ones and R_o = N_i; out_valid_o high in the cycle after the accept.
REQ-021 Overflow (N_i = -2^(width-1), D_i = -1): IDLE->DONE directly, with Q_o = -2^(width-1) and R_o = 0; same latency as REQ-020.
REQ-022 Divide by zero SHALL take priority over overflow; both SHALL be decided only from the values registered at accept.
REQ-023 In DONE, Q_o/R_o SHALL hold stable while out_ready_i=0 (unbounded backpressure).
REQ-024 DONE->IDLE at the edge where out_ready_i=1; no new operand SHALL be accepted in that same cycle, because in_ready_o=0 in DONE.
REQ-025 In_valid_i and operand changes outside IDLE SHALL be ignored; operands SHALL be sampled only at accept.
REQ-026 Q_o/R_o SHALL keep the last result in IDLE and CALC, and SHALL be updated only on entry to DONE.
REQ-027 The most-negative dividend with |D| > 1 SHALL follow the normal path; the internal magnitude datapath SHALL be wide enough that |-2^(width-1)| is exact.

Reset
REQ-028 While rst_i=1 at an edge, the block SHALL go to IDLE and clear the counter, with out_valid_o=0, in_ready_o=1 in the following cycle, and Q_o=0, R_o=0.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation with no result delivered; the first accept after reset SHALL behave like one from power-up.

Verification (width=8)
REQ-030 Accept N=100, D=7 with out_ready_i=1 -> out_valid_o rises 9 edges after accept with Q=14 and R=2, then returns to IDLE next edge.
REQ-031 Sign matrix -> (-100,7) gives Q=-14, R=-2; (100,-7) gives Q=-14, R=2; (-100,-7) gives Q=14, R=-2.
REQ-032 Special cases -> N=0x80, D=0xFF gives Q=0x80, R=0x00; N=37, D=0 gives Q=0xFF, R=37; for both, out_valid_o is high 1 edge after accept; N=0x80, D=0x02 gives Q=0xC0, R=0 after 9 edges.
REQ-033 Backpressure -> hold out_ready_i=0 for 20 cycles in DONE: Q/R stay constant, in_ready_o=0, and a changing N_i/D_i has no effect; one out_ready_i pulse then brings back IDLE.
REQ-034 Reset mid-CALC (edge 4 of 8) -> the next cycle shows out_valid_o=0, in_ready_o=1, Q=R=0; a subsequent accept of 50/3 gives Q=16, R=2 after 9 edges.
REQ-035 Random signed pairs checked against a reference model -> REQ-013 holds for each pair, and latency is 9 (normal) or 1 (special).

Source files
------------

// File: rtl/div_rem_sgn_seq.sv
// Sequential signed divider: radix-2 restoring iteration on operand magnitudes,
// with sign correction and divide-by-zero / overflow short paths.
package lau_pkg;
    typedef enum logic {FAST = 1'b0, SMALL = 1'b1} speed_e;
endpackage

module div_rem_sgn_seq #(
    parameter int             width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] N_i,
    input  logic [width-1:0] D_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] Q_o,
    output logic [width-1:0] R_o
);
    localparam int CW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(width - 1);
    localparam logic [width-1:0] ZERO_W   = {width{1'b0}};
    localparam logic [width-1:0] ONES_W   = {width{1'b1}};
    localparam logic [width-1:0] MIN_W    = {1'b1, {(width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    // Two's complement negate; magnitude of the most negative value stays exact as unsigned.
    function automatic logic [width-1:0] neg(input logic [width-1:0] v);
        neg = ~v + {{(width-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [width-1:0] mag(input logic [width-1:0] v);
        mag = v[width-1] ? neg(v) : v;
    endfunction

    state_e           state_r;
    logic [CW-1:0]    cnt_r;
    logic             sn_r;
    logic             sq_r;
    logic [width-1:0] qn_r;
    logic [width-1:0] ad_r;
    logic [width-1:0] rem_r;
    logic [width-1:0] q_r;
    logic [width-1:0] r_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [width:0]   rem_sh_s;
    logic [width:0]   diff_s;
    logic             ge_s;
    logic [width-1:0] rem_nx_s;
    logic [width-1:0] qn_nx_s;
    logic             div0_s;
    logic             ovf_s;

    assign rem_sh_s = {rem_r, qn_r[width-1]};

    // Trial subtraction; both adder styles yield identical bits.
    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            assign diff_s = rem_sh_s - {1'b0, ad_r};
        end else begin : g_small
            assign diff_s = rem_sh_s + {1'b1, ~ad_r} + {{width{1'b0}}, 1'b1};
        end
    endgenerate

    // One restoring step: keep the difference when it did not go negative.
    always_comb begin
        ge_s     = ~diff_s[width];
        rem_nx_s = rem_sh_s[width-1:0];
        if (ge_s) begin
            rem_nx_s = diff_s[width-1:0];
        end else begin
            rem_nx_s = rem_sh_s[width-1:0];
        end
        qn_nx_s = {qn_r[width-2:0], ge_s};
        div0_s  = (D_i == ZERO_W);
        ovf_s   = (N_i == MIN_W) && (D_i == ONES_W);
    end

    // Control FSM, iteration datapath and registered result/handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            sn_r        <= 1'b0;
            sq_r        <= 1'b0;
            qn_r        <= ZERO_W;
            ad_r        <= ZERO_W;
            rem_r       <= ZERO_W;
            q_r         <= ZERO_W;
            r_r         <= ZERO_W;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        sn_r       <= N_i[width-1];
                        sq_r       <= N_i[width-1] ^ D_i[width-1];
                        qn_r       <= mag(N_i);
                        ad_r       <= mag(D_i);
                        rem_r      <= ZERO_W;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        if (div0_s) begin
                            q_r         <= ONES_W;
                            r_r         <= N_i;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (ovf_s) begin
                            q_r         <= MIN_W;
                            r_r         <= ZERO_W;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_nx_s;
                    qn_r  <= qn_nx_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r       <= {CW{1'b0}};
                        q_r         <= sq_r ? neg(qn_nx_s) : qn_nx_s;
                        r_r         <= sn_r ? neg(rem_nx_s) : rem_nx_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign Q_o         = q_r;
    assign R_o         = r_r;
endmodule

// File: tb/tb_div_rem_sgn_seq.sv
// Self-checking bench for div_rem_sgn_seq (width 8): directed cases plus random
// signed pairs against an integer-arithmetic reference model.
module tb_div_rem_sgn_seq;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] N_i = 8'h00;
    logic [7:0] D_i = 8'h00;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [7:0] Q_o;
    logic [7:0] R_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_q = 8'h00;
    logic [7:0] last_r = 8'h00;

    div_rem_sgn_seq #(.width(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .N_i(N_i), .D_i(D_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .Q_o(Q_o), .R_o(R_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain signed arithmetic (truncating), with the two special cases.
    task automatic ref_div(input logic [7:0] n, input logic [7:0] d,
                           output logic [7:0] q, output logic [7:0] r, output int lat);
        int nn, dd, qq, rr;
        nn = $signed(n);
        dd = $signed(d);
        if (dd == 0) begin
            qq = -1; rr = nn; lat = 1;
        end else if (nn == -128 && dd == -1) begin
            qq = -128; rr = 0; lat = 1;
        end else begin
            qq = nn / dd; rr = nn % dd; lat = 9;
        end
        q = qq[7:0];
        r = rr[7:0];
    endtask

    // Accept one pair and wait for the result; operands are scrambled after accept.
    task automatic do_op(input logic [7:0] n, input logic [7:0] d, input logic rdy,
                         output logic [7:0] q, output logic [7:0] r, output int lat);
        bit hold_ok;
        hold_ok = 1'b1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b want 1", in_ready_o);
        end
        in_valid_i  = 1'b1;
        N_i         = n;
        D_i         = d;
        out_ready_i = rdy;
        @(posedge clk_i); #1;
        lat = 1;
        while (out_valid_o !== 1'b1 && lat < 40) begin
            if (Q_o !== last_q || R_o !== last_r || in_ready_o !== 1'b0) hold_ok = 1'b0;
            in_valid_i = 1'($urandom_range(0, 1));
            N_i = 8'($urandom);
            D_i = 8'($urandom);
            @(posedge clk_i); #1;
            lat++;
        end
        in_valid_i = 1'b0;
        q = Q_o;
        r = R_o;
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL hold_in_calc got changed outputs want q=%h r=%h held", last_q, last_r);
        end
        checks++;
        if (lat >= 40) begin
            errors++;
            $display("FAIL timeout got no out_valid after %0d edges want result", lat);
        end
    endtask

    task automatic check_op(input logic [7:0] n, input logic [7:0] d);
        logic [7:0] eq, er, q, r;
        int elat, lat;
        ref_div(n, d, eq, er, elat);
        do_op(n, d, 1'b1, q, r, lat);
        checks++;
        if (q !== eq || r !== er) begin
            errors++;
            $display("FAIL result n=%h d=%h got q=%h r=%h want q=%h r=%h", n, d, q, r, eq, er);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL latency n=%h d=%h got %0d want %0d", n, d, lat, elat);
        end
        last_q = eq;
        last_r = er;
        @(posedge clk_i); #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || Q_o !== 8'h00 || R_o !== 8'h00) begin
            errors++;
            $display("FAIL reset got rdy=%b vld=%b q=%h r=%h want 1 0 00 00",
                     in_ready_o, out_valid_o, Q_o, R_o);
        end
        last_q = 8'h00;
        last_r = 8'h00;
    endtask

    task automatic test_basic();
        check_op(8'd100, 8'd7);
    endtask

    task automatic test_sign_matrix();
        check_op(8'h9C, 8'd7);
        check_op(8'd100, 8'hF9);
        check_op(8'h9C, 8'hF9);
    endtask

    task automatic test_special();
        check_op(8'h80, 8'hFF);
        check_op(8'd37, 8'h00);
        check_op(8'h80, 8'h02);
        check_op(8'h80, 8'h00);
        check_op(8'h80, 8'h01);
        check_op(8'h7F, 8'h80);
    endtask

    task automatic test_backpressure();
        logic [7:0] eq, er, q, r;
        int elat, lat;
        bit stable_ok;
        ref_div(8'h9C, 8'd7, eq, er, elat);
        do_op(8'h9C, 8'd7, 1'b0, q, r, lat);
        checks++;
        if (q !== eq || r !== er || lat != elat) begin
            errors++;
            $display("FAIL bp_result got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                     q, r, lat, eq, er, elat);
        end
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1;
            N_i = 8'($urandom);
            D_i = 8'($urandom);
            @(posedge clk_i); #1;
            if (Q_o !== eq || R_o !== er || out_valid_o !== 1'b1 || in_ready_o !== 1'b0)
                stable_ok = 1'b0;
        end
        checks++;
        if (!stable_ok) begin
            errors++;
            $display("FAIL bp_hold got q=%h r=%h vld=%b rdy=%b want q=%h r=%h vld=1 rdy=0",
                     Q_o, R_o, out_valid_o, in_ready_o, eq, er);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || Q_o !== eq) begin
            errors++;
            $display("FAIL bp_release got rdy=%b vld=%b q=%h want rdy=1 vld=0 q=%h",
                     in_ready_o, out_valid_o, Q_o, eq);
        end
        last_q = eq;
        last_r = er;
    endtask

    task automatic test_reset_mid_calc();
        in_valid_i = 1'b1;
        N_i = 8'd100;
        D_i = 8'd7;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || Q_o !== 8'h00 || R_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_calc got vld=%b rdy=%b q=%h r=%h want 0 1 00 00",
                     out_valid_o, in_ready_o, Q_o, R_o);
        end
        last_q = 8'h00;
        last_r = 8'h00;
        check_op(8'd50, 8'd3);
    endtask

    task automatic test_random();
        logic [7:0] n, d;
        logic [7:0] pool [5];
        pool[0] = 8'h00; pool[1] = 8'h01; pool[2] = 8'hFF; pool[3] = 8'h80; pool[4] = 8'h7F;
        for (int i = 0; i < 300; i++) begin
            n = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) n = pool[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) d = pool[$urandom_range(0, 4)];
            check_op(n, d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_matrix();
        test_special();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
